// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
// Port indices, arbitration mode encodings and the one-hot grant type live here.
package sram_arb_pkg;

   localparam int NUM_PORTS = 2;
   localparam int PORT0     = 0;
   localparam int PORT1     = 1;

   localparam logic ARB_RR    = 1'b0;
   localparam logic ARB_FIXED = 1'b1;

   typedef logic [NUM_PORTS-1:0] grant_t;

   function automatic grant_t port_onehot(input logic port);
      return port ? grant_t'(2'b10) : grant_t'(2'b01);
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response bus between the two SRAM clients and the arbiter.
// The master side is the client pair; the slave side is the arbiter.
interface sram_arbiter_if #(
   parameter int AW = 11,
   parameter int BW = 32
);

   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    req_wr;
   logic [AW-1:0] req_addr0;
   logic [AW-1:0] req_addr1;
   logic [BW-1:0] req_data0;
   logic [BW-1:0] req_data1;
   logic [1:0]    rsp_valid;
   logic [BW-1:0] rsp_data;

   modport master (
      output req_valid, req_wr, req_addr0, req_addr1, req_data0, req_data1,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_wr, req_addr0, req_addr1, req_data0, req_data1,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational two-way picker producing a one-hot grant.
// A lone valid port always wins; ties go by round-robin or fixed priority.
module arb_pick
   import sram_arb_pkg::*;
(
   input  grant_t valid,
   input  logic   mode,
   input  logic   last_gnt,
   input  logic   starve,
   output grant_t gnt
);

   logic both;

   assign both = valid[PORT0] && valid[PORT1];

   // On a tie round-robin favours the port that did not win last time,
   // while fixed priority favours port 0 until port 1 has starved long enough.
   always_comb begin
      gnt = '0;
      if (!both) begin
         gnt = valid;
      end else begin
         case (mode)
            ARB_RR:    gnt = port_onehot(!last_gnt);
            ARB_FIXED: gnt = port_onehot(starve);
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter and sequencer for a single-port SRAM macro.
// Grants at most one request per cycle, drives the pins and routes read data back.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter  int NUM        = 2048,
   parameter  int BW         = 32,
   parameter  int PRIO_MODE  = 0,
   parameter  int STARVE_MAX = 4,
   localparam int AW         = $clog2(NUM)
) (
   input  logic          clk,
   input  logic          reset,
   sram_arbiter_if.slave bus,
   output logic          sram_CEN,
   output logic          sram_WEN,
   output logic [AW-1:0] sram_A,
   output logic [BW-1:0] sram_D,
   input  logic [BW-1:0] sram_Q
);

   localparam int   SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic MODE = (PRIO_MODE == 1) ? ARB_FIXED : ARB_RR;

   logic          last_gnt;
   logic [SW-1:0] starve_cnt;
   logic          starve;
   grant_t        pick;
   grant_t        gnt;
   logic          gnt_port;
   logic          gnt_wr;
   logic          rd_pend;
   logic          rd_port;

   assign starve = (starve_cnt == SW'(STARVE_MAX));

   arb_pick u_pick (
      .valid    (bus.req_valid),
      .mode     (MODE),
      .last_gnt (last_gnt),
      .starve   (starve),
      .gnt      (pick)
   );

   // Nothing may be granted while reset is held, even if requests are present.
   assign gnt           = reset ? '0 : pick;
   assign gnt_port      = gnt[PORT1];
   assign gnt_wr        = bus.req_wr[gnt_port];
   assign bus.req_ready = gnt;

   // Pin mux: the granted port drives the macro, otherwise park it deselected.
   always_comb begin
      sram_CEN = 1'b1;
      sram_WEN = 1'b1;
      sram_A   = '0;
      sram_D   = '0;
      if (|gnt) begin
         sram_CEN = 1'b0;
         sram_WEN = ~gnt_wr;
         sram_A   = gnt_port ? bus.req_addr1 : bus.req_addr0;
         sram_D   = gnt_port ? bus.req_data1 : bus.req_data0;
      end
   end

   // Arbitration history; starve_cnt saturates so port 1 keeps its forced grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt   <= 1'b1;
         starve_cnt <= '0;
      end else begin
         if (|gnt) begin
            last_gnt <= gnt_port;
         end
         if (bus.req_valid[PORT1] && !gnt[PORT1]) begin
            if (!starve) begin
               starve_cnt <= starve_cnt + SW'(1);
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // The macro registers the read address, so data appears one cycle after the grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_port <= 1'b0;
      end else begin
         rd_pend <= (|gnt) && !gnt_wr;
         rd_port <= gnt_port;
      end
   end

   assign bus.rsp_valid = (rd_pend && !reset) ? port_onehot(rd_port) : '0;
   assign bus.rsp_data  = sram_Q;

endmodule
